// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared pipeline types and constants for the fetch queue.
package cpu_defs_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fq_entry_t;
  localparam logic [31:0] EXC_ADEL  = 32'h00000004;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push, decode-side pop and status signals of the fetch queue.
interface fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(FETCH_W + 1);
  logic                   flush;
  logic [NW-1:0]          push_num;
  logic [31:0]            push_pc;
  logic [32*FETCH_W-1:0]  push_instr;
  logic                   push_ready;
  logic                   pop;
  logic                   out_valid;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic                   out_adel;
  logic [AW:0]            count;
  modport master (
    output flush, push_num, push_pc, push_instr, pop,
    input  push_ready, out_valid, out_pc, out_instr, out_adel, count
  );
  modport slave (
    input  flush, push_num, push_pc, push_instr, pop,
    output push_ready, out_valid, out_pc, out_instr, out_adel, count
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH-entry register array, FETCH_W writes at consecutive addresses, one async read.
module fq_ram
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic [FETCH_W-1:0] we,
  input  logic [AW-1:0]      waddr,
  input  fq_entry_t          wdata [FETCH_W],
  input  logic [AW-1:0]      raddr,
  output fq_entry_t          rdata
);
  fq_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < FETCH_W; i++)
      if (we[i]) mem[waddr + AW'(i)] <= wdata[i];
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer decoupling I-side fetch from decode, tagging AdEL.
module fetch_queue
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(FETCH_W + 1);
  logic [AW-1:0]      rptr, wptr;
  logic [AW:0]        cnt;
  logic               do_push, do_pop;
  logic [NW-1:0]      pushed;
  logic [FETCH_W-1:0] we;
  fq_entry_t          wdata [FETCH_W];
  fq_entry_t          head;
  assign bus.push_ready = cnt <= (AW+1)'(DEPTH - FETCH_W);
  assign bus.out_valid  = cnt != '0;
  assign do_push = (bus.push_num != '0) && bus.push_ready && !bus.flush;
  assign do_pop  = bus.pop && bus.out_valid && !bus.flush;
  assign pushed  = do_push ? bus.push_num : '0;
  always_comb
    for (int i = 0; i < FETCH_W; i++) begin
      we[i]          = do_push && (i < int'(bus.push_num));
      wdata[i].pc    = bus.push_pc + 32'(4 * i);
      wdata[i].instr = bus.push_instr[32*i +: 32];
      wdata[i].adel  = wdata[i].pc[1:0] != 2'b00;
    end
  fq_ram #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .AW(AW)) u_ram (
    .clk(clk), .we(we), .waddr(wptr), .wdata(wdata), .raddr(rptr), .rdata(head)
  );
  // storage is never reset, so the head is masked while the queue is empty
  assign bus.out_pc    = bus.out_valid ? head.pc : 32'h0;
  assign bus.out_instr = (bus.out_valid && !head.adel) ? head.instr : NOP_INSTR;
  assign bus.out_adel  = bus.out_valid && head.adel;
  assign bus.count     = cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + AW'(pushed);
      rptr <= rptr + AW'(do_pop);
      cnt  <= cnt + (AW+1)'(pushed) - (AW+1)'(do_pop);
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus, queue-based reference model and scoreboard.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int FETCH_W = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;
  logic clk = 0;
  logic rst = 0;
  int vec = 0;
  int bad = 0;
  ent_t exp_q [$];
  fetch_queue_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // reference model: a plain queue updated from the accepted-transaction rules
  always @(posedge clk or negedge rst)
    if (!rst) exp_q.delete();
    else if (bus.flush) exp_q.delete();
    else begin
      int n;
      bit can_push;
      n = int'(bus.push_num);
      can_push = (DEPTH - exp_q.size()) >= FETCH_W;
      if (bus.pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (n != 0 && can_push)
        for (int i = 0; i < n; i++) begin
          ent_t e;
          e.pc = bus.push_pc + 4 * i;
          e.instr = bus.push_instr[32*i +: 32];
          e.adel = e.pc[1:0] != 2'b00;
          exp_q.push_back(e);
        end
    end
  always @(negedge clk) begin
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    chk("push_ready", 32'(bus.push_ready), 32'((DEPTH - exp_q.size()) >= FETCH_W));
    if (bus.out_valid && exp_q.size() != 0) begin
      chk("out_pc", bus.out_pc, exp_q[0].pc);
      chk("out_adel", 32'(bus.out_adel), 32'(exp_q[0].adel));
      chk("out_instr", bus.out_instr, exp_q[0].adel ? 32'h0 : exp_q[0].instr);
    end
  end
  task automatic cyc(int n, logic [31:0] pc, logic [31:0] i0, logic [31:0] i1, bit p, bit f);
    bus.push_num = 2'(n);
    bus.push_pc = pc;
    bus.push_instr = {i1, i0};
    bus.pop = p;
    bus.flush = f;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.push_num = 0; bus.push_pc = 0; bus.push_instr = 0; bus.pop = 0; bus.flush = 0;
    #2;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_ready", 32'(bus.push_ready), 1);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_adel", 32'(bus.out_adel), 0);
    #10 rst = 1;
    @(posedge clk); #1;
    cyc(1, 32'hbfc00000, 32'h24010001, 0, 0, 0);
    chk("single_pc", bus.out_pc, 32'hbfc00000);
    chk("single_instr", bus.out_instr, 32'h24010001);
    chk("single_count", 32'(bus.count), 1);
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(2, 32'hbfc00000 + 8 * k, 32'h1000 + k, 32'h2000 + k, 0, 0);
    chk("full_ready", 32'(bus.push_ready), 0);
    chk("full_count", 32'(bus.count), 8);
    cyc(2, 32'hdeadbee0, 1, 2, 0, 0);
    chk("ignored_count", 32'(bus.count), 8);
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", bus.out_pc, 32'hbfc00000 + 4 * k);
      cyc(0, 0, 0, 0, 1, 0);
    end
    for (int k = 0; k < 7; k++) cyc(1, 32'h80000000 + 4 * k, 32'h3000 + k, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 0);
    cyc(2, 32'h80000100, 32'haaaa0000, 32'hbbbb0000, 0, 0);
    chk("wrap_count", 32'(bus.count), 3);
    chk("wrap_head", bus.out_pc, 32'h80000018);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(2, 32'h90000000 + 8 * k, k, k + 1, 0, 0);
    cyc(2, 32'h90000100, 5, 6, 1, 0);
    chk("pp_count", 32'(bus.count), 7);
    chk("pp_ready", 32'(bus.push_ready), 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(2, 32'ha0000000, 1, 2, 0, 0);
    cyc(2, 32'ha0000008, 3, 4, 0, 0);
    cyc(1, 32'ha0000010, 5, 0, 0, 0);
    chk("pre_flush_count", 32'(bus.count), 5);
    cyc(2, 32'ha0000020, 7, 8, 1, 1);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    cyc(1, 32'hbfc00380, 32'h3c1d8000, 0, 0, 0);
    chk("post_flush_pc", bus.out_pc, 32'hbfc00380);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(2, 32'hbfc00002, 32'h12345678, 32'h9abcdef0, 0, 0);
    chk("adel_flag", 32'(bus.out_adel), 1);
    chk("adel_instr", bus.out_instr, 0);
    chk("adel_pc", bus.out_pc, 32'hbfc00002);
    for (int k = 0; k < 600; k++) begin
      int n;
      logic [31:0] pc;
      n = $urandom_range(0, FETCH_W);
      pc = {$urandom(), 2'b00} ;
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      cyc(n, pc, $urandom(), $urandom(), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      if (k == 300) begin
        cyc(2, 32'hc0000000, 1, 2, 0, 0);
        #2 rst = 0;
        #1;
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        bus.push_num = 0; bus.pop = 0; bus.flush = 0;
        #3 rst = 1;
        @(posedge clk); #1;
      end
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
